// File: rtl/spi_arbiter.sv
// spi_arbiter -- round-robin scheduler sharing one SPI master between
// NUM_REQ requesters. Each grant issues exactly one master transaction.
// The received word goes back to the owner together with a one-cycle ack.
// A guard gap of GAP_CYC idle cycles follows every transaction.
// A watchdog aborts a transfer that has not finished after TIMEOUT_CYC
// cycles in WAIT.
//
// Ports:
//   clk, rst_n        system clock (rising edge), async active-low reset
//   req               level request per requester, held until its ack
//   req_data          packed TX words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack               one-cycle completion pulse, one-hot or zero
//   err               one-cycle pulse with ack when the transfer timed out
//   rsp_data          last received word, updated on successful completion
//   grant_id          index of the current or last owner
//   grant_vld         high from ARB exit until DONE exit
//   spi_start         one-cycle start pulse to the master
//   spi_data_in       TX word to the master, stable for the whole transfer
//   spi_busy          master busy; blocks arbitration while high in IDLE
//   spi_finished      master completion pulse, honoured only in WAIT
//   spi_data_out      master RX word, sampled with spi_finished
module spi_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 12,
  parameter int RX_WIDTH    = 16,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          err,
  output logic [RX_WIDTH-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          grant_vld,
  output logic                          spi_start,
  output logic [DATA_WIDTH-1:0]         spi_data_in,
  input  logic                          spi_busy,
  input  logic                          spi_finished,
  input  logic [RX_WIDTH-1:0]           spi_data_out
);

  localparam int ID_W     = $clog2(NUM_REQ);
  localparam int CNT_MAX  = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_START, S_WAIT, S_DONE, S_GAP
  } state_t;

  state_t                state_reg, state_next;
  logic [ID_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]       grant_id_reg;
  logic                  grant_vld_reg;
  logic [DATA_WIDTH-1:0] spi_data_in_reg;
  logic [RX_WIDTH-1:0]   rsp_data_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  timeout_reg;

  logic                  wait_expired;
  logic                  gap_expired;
  logic                  done_cyc;
  logic                  sel_found;
  logic [ID_W-1:0]       sel_idx;
  logic [ID_W-1:0]       cand_idx [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

  genvar gi;

  // Unpack the flat TX bus into one word per requester.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // cand_idx[k] = (rr_ptr + k) mod NUM_REQ. rr_ptr < NUM_REQ always, so
  // one conditional subtract is enough and non-power-of-two sizes work.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [ID_W:0] sum;
      assign sum = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (ID_W+1)'(NUM_REQ))
                          ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                          : sum[ID_W-1:0];
    end
  endgenerate

  // First requester at or after rr_ptr. The scan runs downward so the
  // smallest offset is the last assignment and therefore wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx[k];
      end
    end
  end

  assign wait_expired = (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
  assign gap_expired  = (cnt_reg == CNT_W'(GAP_LAST));
  assign rr_ptr_next  = (grant_id_reg == ID_W'(NUM_REQ - 1))
                      ? '0 : grant_id_reg + ID_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (|req && !spi_busy) state_next = S_ARB;
      S_ARB:   state_next = sel_found ? S_START : S_IDLE;
      S_START: state_next = S_WAIT;
      S_WAIT:  if (spi_finished || wait_expired) state_next = S_DONE;
      S_DONE:  state_next = (GAP_CYC == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gap_expired) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    done_cyc  = (state_reg == S_DONE);
    spi_start = (state_reg == S_START);
    err       = done_cyc && timeout_reg;
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign ack[gi] = done_cyc && (grant_id_reg == ID_W'(gi));
    end
  endgenerate

  // Datapath: grant capture, RX capture, pointer, shared WAIT/GAP counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg      <= '0;
      grant_id_reg    <= '0;
      grant_vld_reg   <= 1'b0;
      spi_data_in_reg <= '0;
      rsp_data_reg    <= '0;
      cnt_reg         <= '0;
      timeout_reg     <= 1'b0;
    end else begin
      if (state_reg == S_ARB && sel_found) begin
        grant_id_reg    <= sel_idx;
        spi_data_in_reg <= req_word[sel_idx];
        grant_vld_reg   <= 1'b1;
      end
      if (state_reg == S_WAIT && spi_finished) rsp_data_reg <= spi_data_out;
      if (done_cyc) begin
        grant_vld_reg <= 1'b0;
        rr_ptr_reg    <= rr_ptr_next;
      end
      // Counter restarts on every state change, so it reads 0 in the first
      // WAIT or GAP cycle.
      if (state_next != state_reg)
        cnt_reg <= '0;
      else if (state_reg == S_WAIT || state_reg == S_GAP)
        cnt_reg <= cnt_reg + CNT_W'(1);
      // A finish in the last WAIT cycle beats the watchdog.
      if (state_reg == S_START)
        timeout_reg <= 1'b0;
      else if (state_reg == S_WAIT && !spi_finished && wait_expired)
        timeout_reg <= 1'b1;
    end
  end

  assign grant_id    = grant_id_reg;
  assign grant_vld   = grant_vld_reg;
  assign spi_data_in = spi_data_in_reg;
  assign rsp_data    = rsp_data_reg;

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter (NUM_REQ=4, GAP_CYC=4, TIMEOUT_CYC=64).
// A cycle table covers a single request, finish-outside-WAIT and the busy
// stall. Hand-written sequences cover mid-WAIT reset, contention, fairness
// and the watchdog.
module tb_spi_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [47:0] req_data;
  logic [3:0]  ack;
  logic        err;
  logic [15:0] rsp_data;
  logic [1:0]  grant_id;
  logic        grant_vld;
  logic        spi_start;
  logic [11:0] spi_data_in;
  logic        spi_busy;
  logic        spi_finished;
  logic [15:0] spi_data_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [11:0] words [4] = '{12'h111, 12'hA5A, 12'h333, 12'h444};

  spi_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(12), .RX_WIDTH(16), .GAP_CYC(4), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .err(err), .rsp_data(rsp_data), .grant_id(grant_id),
    .grant_vld(grant_vld), .spi_start(spi_start), .spi_data_in(spi_data_in),
    .spi_busy(spi_busy), .spi_finished(spi_finished), .spi_data_out(spi_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  typedef struct packed {
    logic [3:0]  req;
    logic        busy;
    logic        fin;
    logic [15:0] dout;
    logic [3:0]  e_ack;
    logic        e_err;
    logic        e_start;
    logic        e_vld;
    logic [1:0]  e_gid;
    logic [11:0] e_din;
    logic [15:0] e_rsp;
  } vec_t;

  vec_t vec [18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (spi_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("start_seen", {31'd0, spi_start}, 32'd1);
  endtask

  // Master model: waits for start, stays busy for lat WAIT cycles, then
  // pulses finished with rx. Returns in the DONE (ack) cycle.
  task automatic serve(input int lat, input logic [15:0] rx, input bit drop,
                       output int gid, output int scyc);
    wait_start();
    gid  = int'(grant_id);
    scyc = cyc;
    chk("tx_word", spi_data_in, words[gid]);
    spi_busy = 1'b1;
    repeat (lat) tick();
    spi_finished = 1'b1;
    spi_data_out = rx;
    tick();
    spi_finished = 1'b0;
    spi_busy     = 1'b0;
    spi_data_out = 16'h0;
    chk("ack", ack, 4'b0001 << gid);
    chk("rsp", rsp_data, rx);
    chk("err", err, 0);
    if (drop) req[gid] = 1'b0;
    $display("xfer: grant=%0d tx=%h rx=%h start_cycle=%0d", gid, spi_data_in, rsp_data, scyc);
  endtask

  initial begin
    int gid, sc, prev_sc, n;

    //          req    bsy   fin   dout      ack    err   st    vld   gid    din      rsp
    vec[0]  = '{4'b0010, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 12'h000, 16'h0000};
    vec[1]  = '{4'b0010, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 12'hA5A, 16'h0000};
    vec[2]  = '{4'b0010, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 12'hA5A, 16'h0000};
    vec[3]  = '{4'b0010, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 12'hA5A, 16'h0000};
    vec[4]  = '{4'b0010, 1'b0, 1'b1, 16'h1234, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 12'hA5A, 16'h1234};
    vec[5]  = '{4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 12'hA5A, 16'h1234};
    vec[6]  = '{4'b0000, 1'b0, 1'b1, 16'hBEEF, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 12'hA5A, 16'h1234};
    vec[7]  = '{4'b0100, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 12'hA5A, 16'h1234};
    vec[8]  = '{4'b0100, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 12'hA5A, 16'h1234};
    vec[9]  = '{4'b0100, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 12'hA5A, 16'h1234};
    vec[10] = '{4'b0100, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 12'hA5A, 16'h1234};
    vec[11] = '{4'b0100, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 12'hA5A, 16'h1234};
    vec[12] = '{4'b0100, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 12'hA5A, 16'h1234};
    vec[13] = '{4'b0100, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 12'h333, 16'h1234};
    vec[14] = '{4'b0100, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 12'h333, 16'h1234};
    vec[15] = '{4'b0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 12'h333, 16'h1234};
    vec[16] = '{4'b0000, 1'b0, 1'b1, 16'h5678, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 12'h333, 16'h5678};
    vec[17] = '{4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 12'h333, 16'h5678};

    rst_n = 1'b0;
    req = '0;
    spi_busy = 1'b0;
    spi_finished = 1'b0;
    spi_data_out = '0;
    for (int i = 0; i < 4; i++) req_data[i*12 +: 12] = words[i];

    // Reset values
    repeat (2) tick();
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rsp", rsp_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_vld", grant_vld, 0);
    chk("rst_start", spi_start, 0);
    chk("rst_din", spi_data_in, 0);
    rst_n = 1'b1;

    // Cycle table: single request, finish in GAP ignored, busy stall.
    for (int i = 0; i < 18; i++) begin
      req          = vec[i].req;
      spi_busy     = vec[i].busy;
      spi_finished = vec[i].fin;
      spi_data_out = vec[i].dout;
      tick();
      chk($sformatf("vec%0d_ack", i),   ack,         vec[i].e_ack);
      chk($sformatf("vec%0d_err", i),   err,         vec[i].e_err);
      chk($sformatf("vec%0d_start", i), spi_start,   vec[i].e_start);
      chk($sformatf("vec%0d_vld", i),   grant_vld,   vec[i].e_vld);
      chk($sformatf("vec%0d_gid", i),   grant_id,    vec[i].e_gid);
      chk($sformatf("vec%0d_din", i),   spi_data_in, vec[i].e_din);
      chk($sformatf("vec%0d_rsp", i),   rsp_data,    vec[i].e_rsp);
    end
    $display("xfer: table of %0d cycle vectors applied", 18);
    req = '0; spi_busy = 1'b0; spi_finished = 1'b0; spi_data_out = '0;

    // Reset mid-WAIT. rr_ptr is 3 here, so req[1] wins via wrap-around.
    req = 4'b0010;
    wait_start();
    chk("rstw_gid", grant_id, 1);
    spi_busy = 1'b1;
    tick();
    tick();
    chk("rstw_vld_pre", grant_vld, 1);
    rst_n = 1'b0;
    #2;
    chk("rstw_ack", ack, 0);
    chk("rstw_err", err, 0);
    chk("rstw_rsp", rsp_data, 0);
    chk("rstw_gid0", grant_id, 0);
    chk("rstw_vld", grant_vld, 0);
    chk("rstw_start", spi_start, 0);
    chk("rstw_din", spi_data_in, 0);
    req = 4'b1000;
    spi_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstw_no_ack", ack, 0);
    end
    rst_n = 1'b1;
    serve(3, 16'h0BAD, 1'b1, gid, sc);
    chk("rstw_post_gid", gid, 3);

    // Contention: all four, each dropping after its ack. rr_ptr wrapped to 0.
    req = 4'b1111;
    prev_sc = 0;
    for (int k = 0; k < 4; k++) begin
      serve(2, 16'hC000 + 16'(k), 1'b1, gid, sc);
      chk($sformatf("cont_gid%0d", k), gid, k);
      if (k > 0) chk($sformatf("cont_gap%0d", k), sc - prev_sc, 2 + 1 + 4 + 3);
      prev_sc = sc;
    end
    req = 4'b1001;
    serve(2, 16'hD000, 1'b1, gid, sc);
    chk("wrap_gid", gid, 0);
    serve(2, 16'hD003, 1'b1, gid, sc);
    chk("wrap_gid2", gid, 3);

    // Fairness: req[0] and req[2] held continuously for 10 transfers.
    req = 4'b0101;
    for (int k = 0; k < 10; k++) begin
      serve(1, 16'hF000 + 16'(k), 1'b0, gid, sc);
      chk($sformatf("fair_gid%0d", k), gid, (k % 2 == 0) ? 0 : 2);
      if (k > 0) chk($sformatf("fair_gap%0d", k), sc - prev_sc, 1 + 1 + 4 + 3);
      prev_sc = sc;
    end
    req = 4'b0000;

    // Watchdog: master never finishes. rr_ptr is 3, so req[1] is granted.
    req = 4'b0010;
    wait_start();
    chk("to_gid", grant_id, 1);
    spi_busy = 1'b1;
    n = 0;
    while (ack == 4'b0000 && n < 200) begin
      tick();
      n++;
    end
    chk("to_latency", n, 65);
    chk("to_ack", ack, 4'b0010);
    chk("to_err", err, 1);
    chk("to_rsp_kept", rsp_data, 16'hF009);
    $display("xfer: grant=1 timed out after %0d cycles", n);
    req = 4'b0000;
    spi_busy = 1'b0;
    tick();
    chk("to_err_pulse", err, 0);
    chk("to_ack_pulse", ack, 0);
    req = 4'b0100;
    serve(2, 16'h7777, 1'b1, gid, sc);
    chk("to_next_gid", gid, 2);

    repeat (8) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin scheduler that shares one SPI master between `NUM_REQ` independent requesters. It sits between client logic (sensor pollers, DAC writers, config loaders) and the SPI master's `start`/`data_in`/`busy`/`finished`/`data_out` handshake. It serializes requests, issues exactly one master transaction per grant, and returns the received word to the owning requester. A guard gap is enforced between transactions, and a watchdog aborts transfers that never finish.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `DATA_WIDTH`, 12: transmit word width. Must equal the SPI master's `DATA_WIDTH`.
- `RX_WIDTH`, 16: width of the master's `data_out`.
- `GAP_CYC`, 4: minimum idle clk cycles between the end of one transaction and the next `spi_start`. Range 0..255.
- `TIMEOUT_CYC`, 4096: clk cycles allowed in WAIT before the transaction is aborted. Range ≥ 16.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req` in NUM_REQ: level request per requester. Held high until that requester's `ack`.
- `req_data` in NUM_REQ*DATA_WIDTH: packed TX words. Requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`. Must be stable while `req[i]` is high.
- `ack` out NUM_REQ: one-cycle completion pulse. One-hot, or zero.
- `err` out 1: one-cycle pulse coincident with `ack` when the transaction timed out.
- `rsp_data` out RX_WIDTH: received word. Valid in the `ack` cycle and held until the next `ack`.
- `grant_id` out clog2(NUM_REQ): index of the current or last owner.
- `grant_vld` out 1: high from ARB exit until DONE exit.
- `spi_start` out 1: one-cycle start pulse to the master.
- `spi_data_in` out DATA_WIDTH: TX word to the master. Held constant for the whole transaction.
- `spi_busy` in 1: master busy.
- `spi_finished` in 1: master completion pulse.
- `spi_data_out` in RX_WIDTH: master RX word. Sampled in the `spi_finished` cycle.

## Operation
- States: IDLE, ARB, START, WAIT, DONE, GAP.
- IDLE → ARB when `req` != 0 and `spi_busy` == 0.
- ARB (1 cycle): select the first set bit of `req` searching upward from `rr_ptr` and wrapping modulo NUM_REQ.
  - Register `grant_id` and `spi_data_in` from `req_data`, and set `grant_vld`.
  - If `req` has dropped to 0 in this cycle, return to IDLE with no grant.
- START (1 cycle): `spi_start`=1 → WAIT.
- WAIT: count cycles.
  - On `spi_finished`=1, capture `spi_data_out` into `rsp_data` → DONE.
  - When the count reaches TIMEOUT_CYC, set the error flag → DONE. `rsp_data` is left unchanged.
- DONE (1 cycle):
  - `ack[grant_id]`=1; `err`=1 if timed out.
  - `rr_ptr` ← (grant_id+1) mod NUM_REQ.
  - Clear `grant_vld`.
  - Next state is GAP, or IDLE if GAP_CYC==0.
- GAP: wait GAP_CYC cycles → IDLE.
- Fairness: any continuously asserted request is served within NUM_REQ grants.
- A `req[i]` that drops while i is granted does not abort the transfer. `ack[i]` is still pulsed.
- `spi_finished` arriving outside WAIT is ignored.
- Requesters must drop `req[i]` in the cycle after `ack[i]` or earlier. A still-high `req` is treated as a new request.

## Timing
- Reset values of outputs:
  - `ack`=0, `err`=0, `rsp_data`=0, `grant_id`=0, `grant_vld`=0, `spi_start`=0, `spi_data_in`=0.
  - Internal: `rr_ptr`=0, state=IDLE.
- Reset asserted mid-transaction returns everything to reset values immediately. No `ack` is generated.
- Latency from `req` rising (in IDLE, master idle, no other request) to `spi_start`: 2 cycles.
  - Edge n: IDLE samples `req`.
  - Edge n+1: ARB.
  - `spi_start` is high during cycle n+2.
- Latency from `spi_finished` high at edge m to `ack` and `rsp_data` valid: high during cycle m+1.
- Back-to-back throughput: the next `spi_start` comes GAP_CYC+3 cycles after `ack`, counting DONE, GAP, IDLE and ARB.
- If `spi_busy` is high in IDLE (master used by another agent), arbitration stalls until it is low.
- Simultaneous requests: the winner is determined solely by `rr_ptr` and the `req` snapshot in the ARB cycle.
- Watchdog: a timeout `ack` occurs TIMEOUT_CYC+1 cycles after START.

## Test plan
- Single request: `req`=4'b0010, `req_data[1]`=12'hA5A; model master returns 16'h1234.
  - Expect `spi_start` 2 cycles after `req`, with `spi_data_in`=12'hA5A.
  - Expect `ack`=4'b0010 and `rsp_data`=16'h1234 one cycle after `finished`.
  - Expect `err`=0.
- Contention: `req`=4'b1111 held, each requester releasing after its `ack`.
  - Expect grant order 0, 1, 2, 3.
  - Then raise `req[0]` and `req[3]` together: expect 0 (pointer wrapped to 0).
- Fairness: `req[0]` and `req[2]` held for 10 transfers.
  - Expect strictly alternating grants 0, 2, 0, 2, ….
  - Expect gap ≥ GAP_CYC+3 cycles between starts.
- Timeout: model never asserts `finished`, TIMEOUT_CYC=64.
  - Expect `ack`+`err` 65 cycles after START.
  - Expect `rsp_data` unchanged, then normal service of the next request.
- Busy stall: hold `spi_busy`=1 with `req`=4'b0100.
  - Expect no `spi_start` while busy.
  - Expect `spi_start` 2 cycles after `spi_busy` falls.
- Reset mid-WAIT: assert `rst_n`=0 during WAIT.
  - Expect all outputs at reset values asynchronously, no `ack`.
  - After release, a pending `req[3]` is granted first via `rr_ptr`=0 search.
